instr_fetch_queue: RTL and testbench

Instruction prefetch stage that sits directly upstream of the pipelined core.
- Generates sequential fetch addresses and reads instruction words from instruction memory.
- Buffers returned words in a small FIFO and presents the head word on `instruction_fetch`, together with `fifo_empty`.
- Pops on the core's `read_fifo`.
- On a taken branch (`branch_valid`/`branch_address` from the core's execute stage), flushes all buffered and in-flight instructions and redirects fetch.

---
 rtl/instr_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Instruction prefetch stage. Issues sequential single-word reads to
//   instruction memory (one outstanding at a time), buffers returned words in
//   a DEPTH-entry FIFO and presents the head word to the core. A taken branch
//   flushes buffered and in-flight words and redirects the fetch PC.
//
// Ports
//   clk               clock, all state on rising edge
//   resetn            asynchronous active-low reset
//   fetch_en          allow new memory requests
//   branch_valid      taken branch: flush and redirect
//   branch_address    redirect target
//   read_fifo         pop head entry
//   imem_rdata        memory read data
//   imem_rvalid       memory read data valid
//   imem_req          one-cycle read request pulse
//   imem_addr         read address, held until the next request
//   instruction_fetch head word, 0 when empty
//   fifo_empty        no buffered word
//   fill_level        buffered word count
module instr_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 11,
    parameter int unsigned DW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned LW   = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          fetch_en,
    input  logic          branch_valid,
    input  logic [AW-1:0] branch_address,
    input  logic          read_fifo,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_rvalid,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] instruction_fetch,
    output logic          fifo_empty,
    output logic [LW-1:0] fill_level
);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   fill_q, fill_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (issue) state_d = StWait;
            // A response in the branch cycle is simply dropped; without one the
            // stale request must still be absorbed before fetching again.
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                end else if (branch_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (imem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs. Only IDLE can issue, so nothing is outstanding there and the
    // reservation check reduces to fill_level < DEPTH.
    always_comb begin
        issue = (state_q == StIdle) && fetch_en && !branch_valid &&
                (fill_q < LW'(DEPTH));
        push  = (state_q == StWait) && imem_rvalid && !branch_valid;
        pop   = read_fifo && (fill_q != '0) && !branch_valid;
    end

    // Datapath next state; branch overrides issue, push and pop.
    always_comb begin
        pc_d     = pc_q;
        req_d    = issue;
        addr_d   = issue ? pc_q : addr_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        fill_d   = fill_q + LW'(push) - LW'(pop);
        if (branch_valid) begin
            pc_d     = branch_address;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else if (issue) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: the output is gated by fifo_empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req          = req_q;
    assign imem_addr         = addr_q;
    assign fill_level        = fill_q;
    assign fifo_empty        = (fill_q == '0);
    assign instruction_fetch = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A background memory model answers
// requests after mem_lat cycles with 0x1000_0000 + addr; man_mode hands the
// response port to the directed sequence instead.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fetch_en = 1'b0;
    logic        branch_valid = 1'b0;
    logic [10:0] branch_address = '0;
    logic        read_fifo = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic [31:0] instruction_fetch;
    logic        fifo_empty;
    logic [2:0]  fill_level;

    int n_cmp = 0;
    int n_fail = 0;

    int          mem_lat = 1;
    bit          man_mode = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          req_count = 0;
    int          resp_count = 0;
    logic [10:0] req_log [256];
    logic        prev_req = 1'b0;

    assign imem_rvalid = man_mode ? man_rvalid : mem_rvalid;
    assign imem_rdata  = man_mode ? man_rdata : mem_rdata;

    instr_fetch_queue #(.DEPTH(4), .AW(11), .DW(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .fetch_en          (fetch_en),
        .branch_valid      (branch_valid),
        .branch_address    (branch_address),
        .read_fifo         (read_fifo),
        .imem_rdata        (imem_rdata),
        .imem_rvalid       (imem_rvalid),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .instruction_fetch (instruction_fetch),
        .fifo_empty        (fifo_empty),
        .fill_level        (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory model, sampled 1 time unit after each rising edge.
    initial begin
        int          cnt;
        bit          pend;
        logic [10:0] paddr;
        cnt = 0;
        pend = 1'b0;
        paddr = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = 32'h1000_0000 + 32'(paddr);
                        pend = 1'b0;
                        resp_count++;
                    end
                end
                if (imem_req) begin
                    check("no_back_to_back", 32'(prev_req), 32'd0);
                    if (req_count < 256) req_log[req_count] = imem_addr;
                    req_count++;
                    if (!man_mode) begin
                        pend = 1'b1;
                        cnt = mem_lat;
                        paddr = imem_addr;
                    end
                end
                prev_req = imem_req;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        int          base;
        int          rc;

        // 1: reset values, then fill with no pops
        fetch_en = 1'b1;
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_fetch", instruction_fetch, 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_fill", 32'(fill_level), 32'd0);
        resetn = 1'b1;
        tick();
        check("t1_first_req", 32'(imem_req), 32'd1);
        check("t1_first_addr", 32'(imem_addr), 32'd0);
        tick();
        check("t1_req_pulse", 32'(imem_req), 32'd0);
        repeat (30) tick();
        check("t1_req_count", 32'(req_count), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_req_addr", 32'(req_log[i]), 32'(i));
        check("t1_fill_sat", 32'(fill_level), 32'd4);
        check("t1_not_empty", 32'(fifo_empty), 32'd0);
        check("t1_head", instruction_fetch, 32'h1000_0000);

        // 2: steady pops, order preserved, NOOP when empty
        exp = 32'h1000_0000;
        for (int i = 0; i < 200 && exp < 32'h1000_000C; i++) begin
            if (fifo_empty) begin
                check("t2_noop", instruction_fetch, 32'd0);
                read_fifo = 1'b0;
            end else begin
                check("t2_order", instruction_fetch, exp);
                exp++;
                read_fifo = 1'b1;
            end
            tick();
        end
        read_fifo = 1'b0;
        check("t2_words_seen", exp, 32'h1000_000C);

        // 3: pc wrap 2047 -> 0
        fetch_en = 1'b0;
        repeat (10) tick();
        base = req_count;
        branch_valid = 1'b1;
        branch_address = 11'd2047;
        read_fifo = 1'b1;
        tick();
        branch_valid = 1'b0;
        fetch_en = 1'b1;
        repeat (20) tick();
        check("t3_addr_2047", 32'(req_log[base]), 32'd2047);
        check("t3_addr_wrap", 32'(req_log[base + 1]), 32'd0);
        read_fifo = 1'b0;

        // 4: branch with 3 buffered and a slow request in flight
        fetch_en = 1'b0;
        repeat (10) tick();
        branch_valid = 1'b1;
        branch_address = 11'd0;
        tick();
        branch_valid = 1'b0;
        check("t4_flushed", 32'(fill_level), 32'd0);
        mem_lat = 1;
        fetch_en = 1'b1;
        for (int i = 0; i < 40 && fill_level != 3'd3; i++) tick();
        check("t4_fill3", 32'(fill_level), 32'd3);
        mem_lat = 4;
        tick();
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_req_addr", 32'(imem_addr), 32'd3);
        rc = resp_count;
        branch_valid = 1'b1;
        branch_address = 11'h100;
        tick();
        branch_valid = 1'b0;
        mem_lat = 1;
        check("t4_empty", 32'(fifo_empty), 32'd1);
        check("t4_fill0", 32'(fill_level), 32'd0);
        check("t4_noop", instruction_fetch, 32'd0);
        for (int i = 0; i < 20 && !imem_req; i++) begin
            check("t4_drain_fill", 32'(fill_level), 32'd0);
            tick();
        end
        check("t4_new_req", 32'(imem_req), 32'd1);
        check("t4_new_addr", 32'(imem_addr), 32'h100);
        check("t4_stale_first", 32'(resp_count), 32'(rc + 1));
        check("t4_stale_dropped", 32'(fill_level), 32'd0);
        for (int i = 0; i < 20 && fifo_empty; i++) tick();
        check("t4_first_word", instruction_fetch, 32'h1000_0100);

        // 5: branch coinciding with response and pop
        repeat (20) tick();
        fetch_en = 1'b0;
        repeat (4) tick();
        check("t5_fill4", 32'(fill_level), 32'd4);
        read_fifo = 1'b1;
        tick();
        tick();
        read_fifo = 1'b0;
        check("t5_fill2", 32'(fill_level), 32'd2);
        check("t5_head", instruction_fetch, 32'h1000_0102);
        man_mode = 1'b1;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_req_addr", 32'(imem_addr), 32'h104);
        tick();
        man_rvalid = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        branch_valid = 1'b1;
        branch_address = 11'h200;
        read_fifo = 1'b1;
        tick();
        man_rvalid = 1'b0;
        branch_valid = 1'b0;
        read_fifo = 1'b0;
        check("t5_fill0", 32'(fill_level), 32'd0);
        check("t5_empty", 32'(fifo_empty), 32'd1);
        check("t5_noop", instruction_fetch, 32'd0);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t5_redirect_req", 32'(imem_req), 32'd1);
        check("t5_redirect_addr", 32'(imem_addr), 32'h200);
        tick();
        man_rvalid = 1'b1;
        man_rdata = 32'hCAFE_0200;
        tick();
        man_rvalid = 1'b0;
        check("t5_push_fill", 32'(fill_level), 32'd1);
        check("t5_push_head", instruction_fetch, 32'hCAFE_0200);

        // 6: reset mid-WAIT, late response ignored
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_req_addr", 32'(imem_addr), 32'h201);
        tick();
        resetn = 1'b0;
        #1;
        check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_addr", 32'(imem_addr), 32'd0);
        check("t6_rst_empty", 32'(fifo_empty), 32'd1);
        check("t6_rst_fill", 32'(fill_level), 32'd0);
        check("t6_rst_fetch", instruction_fetch, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        man_rvalid = 1'b1;
        man_rdata = 32'hBAD0_0BAD;
        tick();
        man_rvalid = 1'b0;
        check("t6_late_fill", 32'(fill_level), 32'd0);
        check("t6_late_empty", 32'(fifo_empty), 32'd1);
        fetch_en = 1'b1;
        tick();
        check("t6_new_req", 32'(imem_req), 32'd1);
        check("t6_new_addr", 32'(imem_addr), 32'd0);
        fetch_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
